// File: rtl/aes_iter_ctrl_if.sv
// Block handshake bundle for the iterative AES engine: plaintext in, ciphertext out,
// plus the busy/round status taps.
interface aes_iter_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;
  logic [3:0]   round;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, round
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, round
  );
endinterface

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor: one shared round datapath reused for ten rounds,
// with a ready/valid block interface on both sides.
module aes_iter_ctrl #(
  parameter logic [127:0] KEY0  = 128'h912FE45AC71B5EF8A2B3C421FE4A0B3F,
  parameter logic [127:0] KEY1  = 128'h62636363626363636263636362636363,
  parameter logic [127:0] KEY2  = 128'h9B9898C9F9FBFBAA9B9898C9F9FBFBAA,
  parameter logic [127:0] KEY3  = 128'h90973450696CCFFAF2F457330B0FAC99,
  parameter logic [127:0] KEY4  = 128'hEE06DA7B876A1581759E42B27E91EE2B,
  parameter logic [127:0] KEY5  = 128'h7F2E2B88F8443E098DDA7CBBF34B9290,
  parameter logic [127:0] KEY6  = 128'hEC614B851425758C99FF09376AB49BA7,
  parameter logic [127:0] KEY7  = 128'h217517873550620BACAF6B3CC61BF09B,
  parameter logic [127:0] KEY8  = 128'h0EF903333BA9613897060A04511DFA9F,
  parameter logic [127:0] KEY9  = 128'hB1D4D8E28A7DB9DA1D7BB3DE4C664941,
  parameter logic [127:0] KEY10 = 128'hB4EF5BCB3E92E21123E951CF6F8F188E
) (
  input  logic           clk,
  input  logic           rst_n,
  aes_iter_ctrl_if.slave bus
);

  // Byte 0 of the table sits in the most significant bits.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       r_state, w_nextState;
  logic [127:0] r_st, w_nextSt;
  logic [3:0]   r_rnd, w_nextRnd;
  logic         w_inReady;
  logic         w_accept;
  logic [127:0] w_roundKey, w_subBytes, w_shifted, w_mixed, w_roundOut;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[11'd2047 - {b, 3'b000} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] byteSub(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Bytes are column-major: byte i lives in row i%4, column i/4.
  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127 - 32*c -: 8];
      a1 = s[119 - 32*c -: 8];
      a2 = s[111 - 32*c -: 8];
      a3 = s[103 - 32*c -: 8];
      o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [127:0] roundKey(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return KEY1;
      4'd2:    return KEY2;
      4'd3:    return KEY3;
      4'd4:    return KEY4;
      4'd5:    return KEY5;
      4'd6:    return KEY6;
      4'd7:    return KEY7;
      4'd8:    return KEY8;
      4'd9:    return KEY9;
      4'd10:   return KEY10;
      default: return '0;
    endcase
  endfunction

  // The single round datapath; the final round skips MixColumns.
  always_comb begin
    w_subBytes = byteSub(r_st);
    w_shifted  = shiftRows(w_subBytes);
    w_mixed    = mixColumns(w_shifted);
    w_roundKey = roundKey(r_rnd);
    w_roundOut = ((r_rnd == 4'd10) ? w_shifted : w_mixed) ^ w_roundKey;
  end

  always_comb begin
    w_nextState = r_state;
    w_nextSt    = r_st;
    w_nextRnd   = r_rnd;
    w_inReady   = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        w_accept  = bus.in_valid;
      end
      RUN: begin
        if (r_rnd >= 4'd1 && r_rnd <= 4'd9) begin
          w_nextSt  = w_roundOut;
          w_nextRnd = r_rnd + 4'd1;
        end else if (r_rnd == 4'd10) begin
          w_nextSt    = w_roundOut;
          w_nextState = DONE;
        end else begin
          w_nextState = IDLE;
          w_nextRnd   = 4'd0;
        end
      end
      DONE: begin
        // Output handshake and a new accept may share the same edge.
        if (bus.out_ready) begin
          w_inReady   = 1'b1;
          w_accept    = bus.in_valid;
          w_nextState = IDLE;
          w_nextRnd   = 4'd0;
        end
      end
      default: begin
        w_nextState = IDLE;
        w_nextRnd   = 4'd0;
      end
    endcase
    if (w_accept) begin
      w_nextSt    = bus.in_data ^ KEY0;
      w_nextRnd   = 4'd1;
      w_nextState = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_st    <= '0;
      r_rnd   <= '0;
    end else begin
      r_state <= w_nextState;
      r_st    <= w_nextSt;
      r_rnd   <= w_nextRnd;
    end
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = (r_state == DONE);
  assign bus.out_data  = r_st;
  assign bus.busy      = (r_state == RUN);
  assign bus.round     = r_rnd;

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Directed self-checking bench for aes_iter_ctrl, with an independent AES reference
// whose S-box is derived arithmetically (GF(2^8) inverse plus affine map).
module tb_aes_iter_ctrl;

  localparam logic [127:0] KEYS [11] = '{
    128'h912FE45AC71B5EF8A2B3C421FE4A0B3F, 128'h62636363626363636263636362636363,
    128'h9B9898C9F9FBFBAA9B9898C9F9FBFBAA, 128'h90973450696CCFFAF2F457330B0FAC99,
    128'hEE06DA7B876A1581759E42B27E91EE2B, 128'h7F2E2B88F8443E098DDA7CBBF34B9290,
    128'hEC614B851425758C99FF09376AB49BA7, 128'h217517873550620BACAF6B3CC61BF09B,
    128'h0EF903333BA9613897060A04511DFA9F, 128'hB1D4D8E28A7DB9DA1D7BB3DE4C664941,
    128'hB4EF5BCB3E92E21123E951CF6F8F188E
  };

  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;
  logic [7:0] sboxTbl [256];

  aes_iter_ctrl_if bus ();

  aes_iter_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = {a[6:0], 1'b0};
      if (hi) a = a ^ 8'h1b;
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] calcSbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aesModel(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] blk;
    blk = pt ^ KEYS[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sboxTbl[blk[127 - 8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c + w] = s[4*((c + w) % 4) + w];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]     = gmul(8'd2, t[4*c]) ^ gmul(8'd3, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c + 1] = t[4*c] ^ gmul(8'd2, t[4*c+1]) ^ gmul(8'd3, t[4*c+2]) ^ t[4*c+3];
          s[4*c + 2] = t[4*c] ^ t[4*c+1] ^ gmul(8'd2, t[4*c+2]) ^ gmul(8'd3, t[4*c+3]);
          s[4*c + 3] = gmul(8'd3, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'd2, t[4*c+3]);
        end
      end else begin
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = s[i];
      blk = blk ^ KEYS[r];
    end
    return blk;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Waits for out_valid; returns maxCycles+1 if it never rises.
  task automatic waitForOutput(input int maxCycles, output int cycles);
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles <= maxCycles) begin
      tick();
      cycles++;
    end
  endtask

  // Runs one block from IDLE to DONE and then drains it.
  task automatic runBlock(input logic [127:0] pt, output logic [127:0] ct, output int cycles);
    bus.in_data   = pt;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    waitForOutput(20, cycles);
    ct = bus.out_data;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data = '0;
    applyReset();
    testsRun++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_flags: got rdy=%b vld=%b busy=%b expected 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
    testsRun++;
    if (bus.round !== 4'd0 || bus.out_data !== 128'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_regs: got round=%0d data=%h expected 0 0", bus.round, bus.out_data);
    end
  endtask

  task automatic test_known_answer();
    logic [127:0] ct;
    int           cycles;
    runBlock(KEYS[0], ct, cycles);
    testsRun++;
    if (ct !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e) begin
      testsFailed++;
      $display("[TB] FAIL kat_zero_state: got %h expected 66e94bd4ef8a2c3b884cfa59ca342b2e", ct);
    end
    runBlock(KEYS[0] ^ {1'b1, 127'b0}, ct, cycles);
    testsRun++;
    if (ct !== 128'h3ad78e726c1ec02b7ebfe92b23d9ec34) begin
      testsFailed++;
      $display("[TB] FAIL kat_msb_state: got %h expected 3ad78e726c1ec02b7ebfe92b23d9ec34", ct);
    end
  endtask

  task automatic test_latency();
    logic [127:0] expCt;
    int           badCycles;
    expCt = aesModel(128'h0);
    applyReset();
    bus.in_data  = 128'h0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    badCycles = 0;
    for (int k = 1; k <= 10; k++) begin
      if (bus.busy !== 1'b1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 ||
          bus.round !== 4'(k)) begin
        badCycles++;
        $display("[TB] FAIL run_status_%0d: got busy=%b vld=%b rdy=%b round=%0d expected 1 0 0 %0d",
                 k, bus.busy, bus.out_valid, bus.in_ready, bus.round, k);
      end
      if (k < 10) tick();
    end
    testsRun++;
    if (badCycles != 0) testsFailed++;
    tick();
    testsRun++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b0 || bus.round !== 4'd10) begin
      testsFailed++;
      $display("[TB] FAIL done_status: got vld=%b busy=%b round=%0d expected 1 0 10",
               bus.out_valid, bus.busy, bus.round);
    end
    testsRun++;
    if (bus.out_data !== expCt) begin
      testsFailed++;
      $display("[TB] FAIL zero_block_data: got %h expected %h", bus.out_data, expCt);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [127:0] pt, expCt, heldData;
    int           cycles, badCycles;
    pt = 128'h00112233445566778899aabbccddeeff;
    expCt = aesModel(pt);
    bus.in_data  = pt;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    waitForOutput(20, cycles);
    heldData = bus.out_data;
    testsRun++;
    if (cycles != 10) begin
      testsFailed++;
      $display("[TB] FAIL stall_latency: got %0d cycles expected 10", cycles);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = ~pt;
    badCycles = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.out_valid !== 1'b1 || bus.out_data !== expCt || bus.in_ready !== 1'b0) begin
        badCycles++;
        $display("[TB] FAIL stall_hold_%0d: got vld=%b rdy=%b data=%h expected 1 0 %h",
                 k, bus.out_valid, bus.in_ready, bus.out_data, expCt);
      end
    end
    testsRun++;
    if (badCycles != 0 || heldData !== expCt) begin
      testsFailed++;
      $display("[TB] FAIL stall_data: got %h expected %h", heldData, expCt);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    testsRun++;
    if (bus.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL done_ready_comb: got %b expected 1", bus.in_ready);
    end
    tick();
    bus.out_ready = 1'b0;
    testsRun++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.round !== 4'd0 || bus.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL release_idle: got vld=%b busy=%b round=%0d rdy=%b expected 0 0 0 1",
               bus.out_valid, bus.busy, bus.round, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] blkA, blkB;
    int           cyclesA, cyclesB;
    blkA = 128'hdeadbeef0123456789abcdeffedcba98;
    blkB = 128'h3243f6a8885a308d313198a2e0370734;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = blkA;
    tick();
    bus.in_data = blkB;
    waitForOutput(20, cyclesA);
    testsRun++;
    if (cyclesA != 10 || bus.out_data !== aesModel(blkA)) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first: got %0d cycles data=%h expected 10 %h",
               cyclesA, bus.out_data, aesModel(blkA));
    end
    tick();
    bus.in_valid = 1'b0;
    testsRun++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1 || bus.round !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_reload: got vld=%b busy=%b round=%0d expected 0 1 1",
               bus.out_valid, bus.busy, bus.round);
    end
    waitForOutput(20, cyclesB);
    testsRun++;
    if (cyclesB + 1 != 11 || bus.out_data !== aesModel(blkB)) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second: got spacing %0d data=%h expected 11 %h",
               cyclesB + 1, bus.out_data, aesModel(blkB));
    end
    tick();
    bus.out_ready = 1'b0;
    testsRun++;
    if (bus.out_valid !== 1'b0 || bus.round !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_idle: got vld=%b round=%0d expected 0 0", bus.out_valid, bus.round);
    end
  endtask

  task automatic test_input_ignored();
    logic [127:0] pt;
    int           cycles;
    pt = 128'hcafef00d5555aaaa0f0f0f0f12345678;
    bus.in_data  = pt;
    bus.in_valid = 1'b1;
    tick();
    cycles = 0;
    while (bus.out_valid !== 1'b1 && cycles <= 20) begin
      bus.in_data  = {$urandom, $urandom, $urandom, $urandom};
      bus.in_valid = 1'($urandom_range(0, 1));
      tick();
      cycles++;
    end
    testsRun++;
    if (cycles != 10 || bus.out_data !== aesModel(pt)) begin
      testsFailed++;
      $display("[TB] FAIL ignore_run_inputs: got %0d cycles data=%h expected 10 %h",
               cycles, bus.out_data, aesModel(pt));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] ct;
    int           cycles, spurious;
    bus.in_data  = 128'h0badc0de0badc0de0badc0de0badc0de;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    cycles = 0;
    while (bus.round !== 4'd5 && cycles < 20) begin
      tick();
      cycles++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    testsRun++;
    if (bus.busy !== 1'b0 || bus.round !== 4'd0 || bus.out_valid !== 1'b0 || bus.out_data !== 128'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_run: got busy=%b round=%0d vld=%b data=%h expected 0 0 0 0",
               bus.busy, bus.round, bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    spurious = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (bus.out_valid !== 1'b0) spurious++;
    end
    bus.out_ready = 1'b0;
    testsRun++;
    if (spurious != 0) begin
      testsFailed++;
      $display("[TB] FAIL discarded_block: got %0d valid cycles expected 0", spurious);
    end
    bus.in_data  = 128'h1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    waitForOutput(20, cycles);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ct = bus.out_data;
    testsRun++;
    if (bus.out_valid !== 1'b0 || ct !== 128'h0 || bus.in_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_in_done: got vld=%b data=%h rdy=%b expected 0 0 1",
               bus.out_valid, ct, bus.in_ready);
    end
  endtask

  task automatic test_reset_with_valid();
    logic [127:0] pt;
    int           cycles;
    pt = 128'hffeeddccbbaa99887766554433221100;
    rst_n        = 1'b0;
    bus.in_data  = pt;
    bus.in_valid = 1'b1;
    tick();
    tick();
    testsRun++;
    if (bus.busy !== 1'b0 || bus.round !== 4'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_blocks_accept: got busy=%b round=%0d expected 0 0", bus.busy, bus.round);
    end
    rst_n = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    testsRun++;
    if (bus.busy !== 1'b1 || bus.round !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL accept_after_reset: got busy=%b round=%0d expected 1 1", bus.busy, bus.round);
    end
    waitForOutput(20, cycles);
    testsRun++;
    if (cycles != 10 || bus.out_data !== aesModel(pt)) begin
      testsFailed++;
      $display("[TB] FAIL post_reset_block: got %0d cycles data=%h expected 10 %h",
               cycles, bus.out_data, aesModel(pt));
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    testsRun      = 0;
    testsFailed   = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 256; i++) sboxTbl[i] = calcSbox(8'(i));
    test_reset();
    test_known_answer();
    test_latency();
    test_stall();
    test_back_to_back();
    test_input_ignored();
    test_reset_mid_run();
    test_reset_with_valid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/aes_iter_ctrl.md
AES_ITER_CTRL -- requirements
Module: aes_iter_ctrl

Interface
REQ-001 KEY0, default 128'h912FE45AC71B5EF8A2B3C421FE4A0B3F, initial whitening key.
REQ-002 KEY1, default 128'h62636363626363636263636362636363, round-1 key.
REQ-003 KEY2, default 128'h9B9898C9F9FBFBAA9B9898C9F9FBFBAA, round-2 key.
REQ-004 KEY3, default 128'h90973450696CCFFAF2F457330B0FAC99, round-3 key.
REQ-005 KEY4, default 128'hEE06DA7B876A1581759E42B27E91EE2B, round-4 key.
REQ-006 KEY5, default 128'h7F2E2B88F8443E098DDA7CBBF34B9290, round-5 key.
REQ-007 KEY6, default 128'hEC614B851425758C99FF09376AB49BA7, round-6 key.
REQ-008 KEY7, default 128'h217517873550620BACAF6B3CC61BF09B, round-7 key.
REQ-009 KEY8, default 128'h0EF903333BA9613897060A04511DFA9F, round-8 key.
REQ-010 KEY9, default 128'hB1D4D8E28A7DB9DA1D7BB3DE4C664941, round-9 key.
REQ-011 KEY10, default 128'hB4EF5BCB3E92E21123E951CF6F8F188E, final-round key.
REQ-012 clk  input  1  single clock; all state changes on rising edge.
REQ-013 rst_n  input  1  reset, synchronous, active-low.
REQ-014 in_valid  input  1  plaintext block offered.
REQ-015 in_ready  output  1  block accepted when in_valid && in_ready at a rising edge.
REQ-016 in_data  input  128  plaintext block.
REQ-017 out_valid  output  1  ciphertext available.
REQ-018 out_ready  input  1  consumer accepts ciphertext when out_valid && out_ready at a rising edge.
REQ-019 out_data  output  128  ciphertext block.
REQ-020 busy  output  1  high in RUN.
REQ-021 round  output  4  round about to be applied (0 in IDLE, 1..10 in RUN, 10 in DONE).

Function
REQ-022 Block shall iterate one shared round datapath (existing round_key, round_eval, byte_sub, shift_rows submodules), with no instance duplicated per round.
REQ-023 FSM states IDLE, RUN, DONE; 128-bit state register st; 4-bit counter rnd.
REQ-024 IDLE: in_ready=1; on accept, st <= in_data ^ KEY0, rnd <= 1, go RUN.
REQ-025 RUN, rnd 1..9: st <= round_eval(st, KEYrnd), rnd <= rnd+1.
REQ-026 RUN, rnd 10: st <= shift_rows(byte_sub(st)) ^ KEY10, go DONE, out_valid <= 1.
REQ-027 Latency: out_valid high exactly 10 rising edges after the accepting edge; throughput one block per 11 cycles minimum.
REQ-028 DONE: out_data = st, held stable while out_valid && !out_ready.
REQ-029 DONE with out_ready=0: in_ready=0, state held indefinitely.
REQ-030 DONE with out_ready=1: in_ready=1; if in_valid also high, the same edge completes output and loads the new block (st <= in_data ^ KEY0, rnd <= 1, go RUN, out_valid <= 0); otherwise go IDLE, rnd <= 0.
REQ-031 in_ready shall be 0 throughout RUN; in_valid/in_data changes during RUN shall be ignored.
REQ-032 out_valid shall be 0 in IDLE and RUN; out_data shall not be read outside DONE (value unspecified except after reset).
REQ-033 rnd shall never exceed 10; any illegal encoding shall return to IDLE on the next edge.
REQ-034 in_ready is a combinational function of state and out_ready only (never of in_valid).

Reset
REQ-035 rst_n low at a rising edge shall force IDLE, rnd=0, st=0, out_valid=0, busy=0, out_data=0, in_ready=1 afterwards, regardless of state.
REQ-036 Reset mid-RUN or in DONE shall discard the block with no out_valid pulse; reset overrides simultaneous accept.

Verification
REQ-037 Reset, then in_data=128'h0 accepted at edge E0 -> busy=1 edges E1..E9, round counts 1..10, out_valid=1 after E10, out_data equals software AES model using KEY0..KEY10.
REQ-038 out_ready=0 for 5 cycles after out_valid -> out_data, out_valid unchanged, in_ready=0; release -> IDLE next edge.
REQ-039 Back-to-back: out_ready=1, in_valid=1 held with in_data=A then B -> B accepted on edge A is output; outputs spaced 11 cycles, both match model.
REQ-040 in_data toggled to random values during RUN -> result matches model of the originally accepted block.
REQ-041 rst_n low at round 5 -> next cycle IDLE, round=0, out_valid=0; no output ever appears for that block.
REQ-042 Reset with in_valid=1 -> block not accepted; acceptance occurs on first edge with rst_n=1.
